// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, port
// indices and default RAM geometry.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 16;

  // Port indices; the processor is port 0, the loader/debug path is port 1.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // Arbiter FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin winner selection. Purely combinational; the caller
// decides when to act on the result and owns the last_grant register.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_winner
);

  // A lone requester always wins; on a tie the port that did not win last time goes.
  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = PORT_CPU;
    if (i_req0 && i_req1) begin
      o_winner = ~i_last_grant;
    end else if (i_req1) begin
      o_winner = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM with a fixed
// read latency. One transaction is in flight at a time.
//
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until it sees its one-cycle gnt pulse. Requests are sampled only at the
// edge that ends an IDLE cycle; a req that is low at that edge is simply not
// seen. After gnt the requester may change or drop its inputs; completion is
// the one-cycle ack pulse, and for a read rdata is valid while ack is high
// (it then holds until the next read completes). A req still high in the
// IDLE cycle after its ack is treated as a fresh request.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_owner,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [1:0]        o_dbg_state
);

  localparam logic [2:0] LAT = 3'(READ_LAT);

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_valid;
  logic              w_winner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_access;
  logic              w_ack;

  rr_arb2 u_rr_arb2 (
    .i_req0       (i_req0),
    .i_req1       (i_req1),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_winner     (w_winner)
  );

  // Steer the winning port's request fields toward the latch.
  always_comb begin
    w_sel_we    = (w_winner == PORT_LDR) ? i_we1    : i_we0;
    w_sel_addr  = (w_winner == PORT_LDR) ? i_addr1  : i_addr0;
    w_sel_wdata = (w_winner == PORT_LDR) ? i_wdata1 : i_wdata0;
  end

  // Transaction FSM: arbitrate in IDLE, drive the RAM for one ACCESS cycle,
  // wait out the read latency, then acknowledge for one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 3'd0;
      r_owner      <= PORT_CPU;
      r_last_grant <= PORT_LDR;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_owner      <= w_winner;
            r_last_grant <= w_winner;
            r_we         <= w_sel_we;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (r_we) begin
            r_state <= ST_ACK;
          end else begin
            r_cnt   <= LAT;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The RAM output is valid during the last WAIT cycle.
          if (r_cnt == 3'd1) begin
            r_rdata <= i_mem_rdata;
            r_cnt   <= 3'd0;
            r_state <= ST_ACK;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode; pulses are pure state decodes so reset clears them at once.
  always_comb begin
    w_access    = (r_state == ST_ACCESS);
    w_ack       = (r_state == ST_ACK);
    o_gnt0      = w_access && (r_owner == PORT_CPU);
    o_gnt1      = w_access && (r_owner == PORT_LDR);
    o_ack0      = w_ack && (r_owner == PORT_CPU);
    o_ack1      = w_ack && (r_owner == PORT_LDR);
    o_mem_we    = w_access && r_we;
    o_busy      = (r_state != ST_IDLE);
    o_owner     = r_owner;
    o_mem_addr  = r_addr;
    o_mem_wdata = r_wdata;
    o_rdata     = r_rdata;
    o_dbg_state = r_state;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM, a transaction-timeline reference
// model, directed scenarios with literal expectations, then random traffic.
module tb_mem_arbiter;

  localparam int L  = 2;
  localparam int AW = 5;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, ack0, ack1, busy, owner, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  mem_arbiter #(.READ_LAT(L), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_ack0(ack0), .o_ack1(ack1),
    .o_rdata(rdata), .o_busy(busy), .o_owner(owner),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata), .o_dbg_state(dbg_state)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 1237 + 32'h0F0F);
  endfunction

  // ---------------- behavioural RAM (READ_LAT pipeline) ----------------
  logic [DW-1:0] ram  [0:(1<<AW)-1];
  logic [DW-1:0] pipe [0:L-1];
  bit ram_loaded = 0;
  assign mem_rdata = pipe[L-1];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= init_val(i);
      ram_loaded <= 1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    pipe[0] <= ram[mem_addr];
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 60)
        $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transaction is a timeline: k=1 is the grant cycle, k=dur the ack cycle
  // (dur = 2 for writes, 2+L for reads), then one IDLE cycle before the next
  // arbitration.
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  bit            sh_loaded = 0;
  bit            m_active;
  int            m_k, m_dur;
  logic          m_we, m_owner, m_last, m_p;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!sh_loaded) begin
      for (int i = 0; i < (1<<AW); i++) shadow[i] = init_val(i);
      sh_loaded = 1;
    end
    if (!rst_n) begin
      m_active = 0; m_k = 0; m_dur = 0; m_we = 0; m_owner = 0; m_last = 1;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_pend = '0;
    end else if (!m_active) begin
      if (req0 || req1) begin
        m_p      = (req0 && req1) ? ~m_last : req1;
        m_active = 1;
        m_k      = 1;
        m_owner  = m_p;
        m_last   = m_p;
        m_we     = m_p ? we1 : we0;
        m_addr   = m_p ? addr1 : addr0;
        m_wdata  = m_p ? wdata1 : wdata0;
        m_dur    = m_we ? 2 : 2 + L;
      end
    end else begin
      // RAM is touched at the end of the grant cycle.
      if (m_k == 1) begin
        if (m_we) shadow[m_addr] = m_wdata;
        else      m_pend = shadow[m_addr];
      end
      m_k++;
      if (m_k == m_dur && !m_we) m_rdata = m_pend;
      if (m_k > m_dur) begin
        m_active = 0;
        m_k = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt0",      gnt0,      m_active && m_k == 1 && m_owner == 0);
      chk("gnt1",      gnt1,      m_active && m_k == 1 && m_owner == 1);
      chk("ack0",      ack0,      m_active && m_k == m_dur && m_owner == 0);
      chk("ack1",      ack1,      m_active && m_k == m_dur && m_owner == 1);
      chk("mem_we",    mem_we,    m_active && m_k == 1 && m_we);
      chk("busy",      busy,      m_active);
      chk("owner",     owner,     m_owner);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("rdata",     rdata,     m_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic rand_port(input logic g, inout logic r, inout logic w,
                           inout logic [AW-1:0] a, inout logic [DW-1:0] d);
    if (r && g) begin
      if ($urandom_range(1, 0) == 0) r = 0;
      else begin w = 1'($urandom); a = AW'($urandom); d = DW'($urandom); end
    end else if (r) begin
      if ($urandom_range(15, 0) == 0) r = 0;
    end else if ($urandom_range(2, 0) == 0) begin
      r = 1; w = 1'($urandom); a = AW'($urandom); d = DW'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int   n, order[3], own[3];
  logic seen;

  initial begin
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    tick();
    chk_en = 1;

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_we", mem_we, 0);

    // tie after reset: 0, 1, 0
    order = '{-1, -1, -1}; own = '{-1, -1, -1};
    req0 = 1; we0 = 1; addr0 = 5'd10; wdata0 = 16'h1111;
    req1 = 1; we1 = 1; addr1 = 5'd11; wdata1 = 16'h2222;
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      tick();
      if (gnt0 || gnt1) begin order[n] = int'(gnt1); own[n] = int'(owner); n++; end
    end
    req0 = 0; req1 = 0;
    chk("tie_count", n, 3);
    chk("tie_first", order[0], 0);
    chk("tie_second", order[1], 1);
    chk("tie_third", order[2], 0);
    chk("tie_owner1", own[1], 1);
    chk("tie_owner2", own[2], 0);
    wait_idle();

    // single write
    req0 = 1; we0 = 1; addr0 = 5'h03; wdata0 = 16'hABCD;
    tick();
    chk("wr_gnt0", gnt0, 1);
    chk("wr_gnt1", gnt1, 0);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 5'h03);
    req0 = 0;
    tick();
    chk("wr_ack0", ack0, 1);
    chk("wr_we_low", mem_we, 0);
    tick();
    chk("wr_ram3", ram[3], 16'hABCD);
    wait_idle();

    // single read, READ_LAT=2
    req1 = 1; we1 = 0; addr1 = 5'h03;
    tick();
    chk("rd_gnt1", gnt1, 1);
    req1 = 0;
    tick();
    chk("rd_noack_t2", ack1, 0);
    tick();
    chk("rd_noack_t3", ack1, 0);
    tick();
    chk("rd_ack1_t4", ack1, 1);
    chk("rd_rdata", rdata, 16'hABCD);
    wait_idle();

    // late request during WAIT
    req0 = 1; we0 = 0; addr0 = 5'd10;
    tick();
    req0 = 0;
    tick();
    req1 = 1; we1 = 0; addr1 = 5'h03;
    n = 0;
    while (!ack0 && n < 20) begin tick(); n++; end
    chk("late_ack0_seen", ack0, 1);
    chk("late_rdata0", rdata, 16'h1111);
    n = 0;
    while (!gnt1 && n < 10) begin tick(); n++; end
    chk("late_gnt1_delay", n, 2);
    req1 = 0;
    n = 0;
    while (!ack1 && n < 20) begin tick(); n++; end
    chk("late_ack1_rdata", rdata, 16'hABCD);
    wait_idle();

    // reset during WAIT
    req0 = 1; we0 = 0; addr0 = 5'h03;
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_mem_we", mem_we, 0);
    chk("rstw_ack0", ack0, 0);
    chk("rstw_owner", owner, 0);
    chk("rstw_rdata", rdata, 0);
    @(posedge clk);
    #3 rst_n = 1;
    n = 0;
    while (!gnt0 && n < 6) begin tick(); n++; end
    chk("rstw_regrant", (gnt0 && n <= 2) ? 1 : 0, 1);
    req0 = 0;
    wait_idle();

    // withdrawn request
    req1 = 1; we1 = 0; addr1 = 5'd4;
    tick();
    req1 = 0;
    tick();
    req0 = 1; we0 = 1; addr0 = 5'd9; wdata0 = 16'h1234;
    tick();
    req0 = 0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      seen = seen | gnt0 | ack0 | mem_we;
    end
    chk("wd_no_gnt0", seen, 0);
    chk("wd_ram9", ram[9], init_val(9));

    // random traffic with occasional mid-transaction reset
    for (int c = 0; c < 2000; c++) begin
      tick();
      if ($urandom_range(299, 0) == 0) begin
        #2 rst_n = 0;
        @(posedge clk);
        #3 rst_n = 1;
      end else begin
        rand_port(gnt0, req0, we0, addr0, wdata0);
        rand_port(gnt1, req1, we1, addr1, wdata1);
      end
    end
    req0 = 0; req1 = 0;
    tick();
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter READ_LAT, default 2, meaning cycles from the RAM address cycle to valid mem_rdata; legal range 1..4.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning RAM address width.
REQ-003 SHALL have parameter DATA_W, default 16, meaning RAM data width.
REQ-004 Clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Resetn  in  1  reset, asynchronous, active-low.
REQ-006 req0, req1  in  1 each  access request, port 0 = processor, port 1 = loader/debug.
REQ-007 we0, we1  in  1 each  1 = write, 0 = read.
REQ-008 addr0, addr1  in  ADDR_W each  word address.
REQ-009 wdata0, wdata1  in  DATA_W each  write data.
REQ-010 gnt0, gnt1  out  1 each  one-cycle grant pulse.
REQ-011 ack0, ack1  out  1 each  one-cycle completion pulse.
REQ-012 rdata  out  DATA_W  read data, valid while ack0 or ack1 is high for a read.
REQ-013 busy  out  1  transaction in progress (any state except IDLE).
REQ-014 owner  out  1  index of port currently or last granted.
REQ-015 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_we  out  1; mem_rdata  in  DATA_W  single-port RAM side.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, WAIT, ACK; exactly one transaction in flight.
REQ-017 Arbitration SHALL occur only in IDLE; requests sampled at the rising edge that ends the IDLE cycle.
REQ-018 One requester active: it wins; both active: the port not equal to last_grant wins (round robin); last_grant resets to 1 so port 0 wins the first tie.
REQ-019 On a win, at the same edge: latch addr/we/wdata of the winner into mem_addr/mem_wdata/latched-we, set owner and last_grant, go to ACCESS.
REQ-020 In ACCESS: gnt<owner> = 1 for that cycle only; mem_we = latched-we for that cycle only; the other port's gnt = 0.
REQ-021 Write: ACCESS -> ACK; request at IDLE cycle T gives gnt in T+1 and ack in T+2.
REQ-022 Read: ACCESS -> WAIT for exactly READ_LAT cycles (down-counter); mem_rdata captured into rdata at the end of the last WAIT cycle; ack in T+2+READ_LAT.
REQ-023 ACK: ack<owner> = 1 for one cycle; rdata held until the next read capture; next state IDLE unconditionally.
REQ-024 Requester SHALL hold req/we/addr/wdata stable until its gnt; a req still high in the IDLE cycle after its ACK is a new request.
REQ-025 A req dropped before sampling in IDLE SHALL be ignored; no gnt, no ack.
REQ-026 Requests arriving during ACCESS/WAIT/ACK SHALL wait; the maximum wait for either port is one other transaction.
REQ-027 mem_addr/mem_wdata SHALL hold their values outside ACCESS; mem_we SHALL be 0 in every state except ACCESS.
REQ-028 gnt0&gnt1 and ack0&ack1 SHALL never be 1 simultaneously.

Reset
REQ-029 Resetn low SHALL immediately force: state IDLE, gnt/ack 0, mem_we 0, busy 0, owner 0, last_grant 1, mem_addr 0, mem_wdata 0, rdata 0, WAIT counter 0.
REQ-030 Reset mid-transaction SHALL abort it with no ack; the first cycle after release is IDLE.

Structure
REQ-031 Shared package mem_arb_pkg SHALL hold state encoding (IDLE, ACCESS, WAIT, ACK), port index constants (PORT_CPU = 0, PORT_LDR = 1), and default ADDR_W/DATA_W.
REQ-032 Winner selection SHALL be a combinational sub-module rr_arb2 (inputs req0, req1, last_grant; outputs valid, winner).

Verification
REQ-033 Single write: req0=1 we0=1 addr0=5'h03 wdata0=16'hABCD at T -> gnt0 at T+1 with mem_we=1 and mem_addr=03; ack0 at T+2; RAM[3]=ABCD.
REQ-034 Single read, READ_LAT=2: req1 read addr1=5'h03 -> gnt1 at T+1, ack1 at T+4, rdata=16'hABCD.
REQ-035 Tie after reset: req0 and req1 both held -> port 0, then port 1, then port 0 granted; owner toggles each transaction.
REQ-036 Late request: req1 raised during port 0's WAIT -> granted in ACCESS directly after port 0's ACK+IDLE; no lost request.
REQ-037 Reset in WAIT: Resetn low -> busy=0 and mem_we=0 immediately, no ack; after release, a held req0 is granted within 2 cycles.
REQ-038 Withdrawn request: req0 pulsed for one non-IDLE cycle only -> no gnt0, no ack0, no mem_we.
